npg_top: RTL and testbench



---
 rtl/npg_pkg.sv | 56 +++++
 rtl/npg_if.sv | 9 +
 rtl/npg_clk_div.sv | 36 +++
 rtl/npg_top.sv | 147 ++++++++++++++
 tb/tb_npg_top.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/npg_pkg.sv
// Shared definitions for the neural pulse generator: state encoding, H-bridge
// switch patterns, default timing and the state-to-output decode.
package npg_pkg;

  typedef logic [2:0] npg_state_t;

  localparam npg_state_t ST_IDLE       = 3'd0;
  localparam npg_state_t ST_CATHODIC   = 3'd1;
  localparam npg_state_t ST_INTERPHASE = 3'd2;
  localparam npg_state_t ST_ANODIC     = 3'd3;
  localparam npg_state_t ST_DISCHARGE  = 3'd4;

  localparam logic [2:0] SW_OFF   = 3'b000;
  localparam logic [2:0] SW_LEG_A = 3'b001;
  localparam logic [2:0] SW_LEG_B = 3'b010;
  localparam logic [2:0] SW_SHORT = 3'b111;

  localparam int         DEF_DIV_HALF         = 625;
  localparam int         DEF_PERIOD_TICKS     = 2000;
  localparam int         DEF_PHASE_TICKS      = 4;
  localparam int         DEF_INTERPHASE_TICKS = 1;
  localparam int         DEF_DISCHARGE_TICKS  = 2;
  localparam logic [5:0] DEF_AMPLITUDE        = 6'd32;

  // Field order matches the gn[13:1] pin layout.
  typedef struct packed {
    logic       active;
    logic [5:0] dac;
    logic [2:0] down;
    logic [2:0] up;
  } npg_drive_t;

  function automatic npg_drive_t drive_for(npg_state_t st, logic [5:0] amp);
    npg_drive_t d;
    d = '0;
    case (st)
      ST_CATHODIC: begin
        d.up     = SW_LEG_A;
        d.down   = SW_LEG_B;
        d.dac    = amp;
        d.active = 1'b1;
      end
      ST_INTERPHASE: d.active = 1'b1;
      ST_ANODIC: begin
        d.up     = SW_LEG_B;
        d.down   = SW_LEG_A;
        d.dac    = amp;
        d.active = 1'b1;
      end
      ST_DISCHARGE: d.down = SW_SHORT;
      default: d.up = SW_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/npg_if.sv
// Link between the clock divider and the pulse sequencer: the exported
// 20 kHz clock and the one-cycle tick strobe on its rising edge.
interface npg_if;
  logic clk_20khz;
  logic tick;

  modport master (output clk_20khz, output tick);
  modport slave  (input  clk_20khz, input  tick);
endinterface

// File: rtl/npg_clk_div.sv
// Divides the board clock to the stimulation tick rate; tick is high in the
// cycle whose closing edge raises clk_20khz.
module npg_clk_div
  import npg_pkg::*;
#(
  parameter int DIV_HALF = DEF_DIV_HALF
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  npg_if.master o_div
);

  localparam int CNT_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV_HALF - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_div.clk_20khz = r_clk;
  assign o_div.tick      = w_wrap & ~r_clk;

endmodule

// File: rtl/npg_top.sv
// ASKA neural pulse generator board top: periodic biphasic, charge-balanced
// pulses sequenced on the 20 kHz tick, with a synchronous abort on enable low.
module npg_top
  import npg_pkg::*;
#(
  parameter int         DIV_HALF         = DEF_DIV_HALF,
  parameter int         PERIOD_TICKS     = DEF_PERIOD_TICKS,
  parameter int         PHASE_TICKS      = DEF_PHASE_TICKS,
  parameter int         INTERPHASE_TICKS = DEF_INTERPHASE_TICKS,
  parameter int         DISCHARGE_TICKS  = DEF_DISCHARGE_TICKS,
  parameter logic [5:0] AMPLITUDE        = DEF_AMPLITUDE
) (
  input  logic        clk_25mhz,
  input  logic [5:0]  gp,
  input  logic [6:0]  btn,
  output logic [13:0] gn,
  output logic [7:0]  led
);

  localparam int PH_MAX0 = (PHASE_TICKS > INTERPHASE_TICKS) ? PHASE_TICKS : INTERPHASE_TICKS;
  localparam int PH_MAX  = (PH_MAX0 > DISCHARGE_TICKS) ? PH_MAX0 : DISCHARGE_TICKS;
  localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int PER_W   = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

  logic             w_rst_n;
  logic             w_tick;
  logic             w_unused;
  logic             r_en_meta;
  logic             r_en_sync;
  npg_state_t       r_state;
  npg_state_t       w_state_next;
  logic [PH_W-1:0]  r_phase;
  logic [PH_W-1:0]  w_phase_next;
  logic [PER_W-1:0] r_period;
  logic [5:0]       r_pulse_cnt;
  logic             w_start;
  npg_drive_t       r_drive;

  assign w_rst_n  = gp[0];
  assign w_unused = ^{btn, gp[5:2]};

  npg_if w_div_if ();

  npg_clk_div #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_div (
    .i_clk   (clk_25mhz),
    .i_rst_n (w_rst_n),
    .o_div   (w_div_if.master)
  );

  assign w_tick = w_div_if.tick;

  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_en_meta <= 1'b0;
      r_en_sync <= 1'b0;
    end else begin
      r_en_meta <= gp[1];
      r_en_sync <= r_en_meta;
    end
  end

  // Enable low forces IDLE on the very next clock, independent of the tick.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_start      = 1'b0;
    if (!r_en_sync) begin
      w_state_next = ST_IDLE;
      w_phase_next = '0;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (r_period == '0) begin
            w_state_next = ST_CATHODIC;
            w_phase_next = '0;
            w_start      = 1'b1;
          end
        end
        ST_CATHODIC: begin
          if (r_phase == PH_W'(PHASE_TICKS - 1)) begin
            w_state_next = ST_INTERPHASE;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase + 1'b1;
          end
        end
        ST_INTERPHASE: begin
          if (r_phase == PH_W'(INTERPHASE_TICKS - 1)) begin
            w_state_next = ST_ANODIC;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase + 1'b1;
          end
        end
        ST_ANODIC: begin
          if (r_phase == PH_W'(PHASE_TICKS - 1)) begin
            w_state_next = ST_DISCHARGE;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase + 1'b1;
          end
        end
        ST_DISCHARGE: begin
          if (r_phase == PH_W'(DISCHARGE_TICKS - 1)) begin
            w_state_next = ST_IDLE;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase + 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_phase_next = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so pins move on the same edge as the FSM.
  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_period    <= '0;
      r_pulse_cnt <= '0;
      r_drive     <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_drive <= drive_for(w_state_next, AMPLITUDE);
      if (!r_en_sync) begin
        r_period <= '0;
      end else if (w_tick) begin
        r_period <= (r_period == PER_W'(PERIOD_TICKS - 1)) ? '0 : r_period + 1'b1;
      end
      if (w_start) begin
        r_pulse_cnt <= r_pulse_cnt + 1'b1;
      end
    end
  end

  assign gn  = {r_drive, w_div_if.clk_20khz};
  assign led = {r_drive.active, r_en_sync, r_pulse_cnt};

endmodule

// File: tb/tb_npg_top.sv
// Scoreboard bench for npg_top with a shortened divider and period; expected
// pin-shape changes are queued with the cycle they must appear on.
module tb_npg_top;

  localparam int DIV_HALF     = 10;
  localparam int PERIOD_TICKS = 20;
  localparam int TICK_CYC     = 2 * DIV_HALF;
  localparam int PULSE_CYC    = PERIOD_TICKS * TICK_CYC;

  localparam logic [12:0] SH_IDLE  = 13'h0000;
  localparam logic [12:0] SH_CATH  = {1'b1, 6'd32, 3'b010, 3'b001};
  localparam logic [12:0] SH_INTER = {1'b1, 6'd0,  3'b000, 3'b000};
  localparam logic [12:0] SH_ANOD  = {1'b1, 6'd32, 3'b001, 3'b010};
  localparam logic [12:0] SH_DISCH = {1'b0, 6'd0,  3'b111, 3'b000};

  typedef struct {
    logic [12:0] shape;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [5:0]  gp;
  logic [6:0]  btn;
  logic [13:0] gn;
  logic [7:0]  led;
  logic        clk20_prev;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   n_rise = 0;

  always #5 clk = ~clk;

  npg_if tb_if ();
  assign tb_if.clk_20khz = gn[0];
  assign tb_if.tick      = gn[0] & ~clk20_prev;

  npg_top #(
    .DIV_HALF     (DIV_HALF),
    .PERIOD_TICKS (PERIOD_TICKS)
  ) dut (
    .clk_25mhz (clk),
    .gp        (gp),
    .btn       (btn),
    .gn        (gn),
    .led       (led)
  );

  // Edges since reset release; sampled on the falling edge it equals the edge index.
  always @(posedge clk) begin
    if (gp[0] === 1'b1) cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input logic [12:0] shape, input int at);
    exp_t e;
    e.shape = shape;
    e.cyc   = at;
    sb_q.push_back(e);
  endtask

  task automatic push_pulse(input int s);
    push(SH_CATH,  s);
    push(SH_INTER, s + 4 * TICK_CYC);
    push(SH_ANOD,  s + 5 * TICK_CYC);
    push(SH_DISCH, s + 9 * TICK_CYC);
    push(SH_IDLE,  s + 11 * TICK_CYC);
  endtask

  // First clk_20khz rise that sees enable through the 2-flop synchroniser.
  function automatic int next_tick(input int c);
    int n;
    n = DIV_HALF;
    while (n < c + 3) n += TICK_CYC;
    return n;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin : monitor
    logic [12:0] shape;
    logic [12:0] prev_shape;
    logic        exp_lvl;
    exp_t        e;
    prev_shape = '0;
    clk20_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (gp[0] !== 1'b1) begin
        prev_shape = '0;
        clk20_prev = 1'b0;
        continue;
      end
      shape = gn[13:1];
      if ((shape[2:0] & shape[5:3]) != 3'b000) begin
        n_miss++;
        $display("FAIL bridge_overlap: up=%b down=%b, required no common bit (cycle %0d)",
                 shape[2:0], shape[5:3], cyc);
      end
      if (shape[11:6] != 6'd0 && shape != SH_CATH && shape != SH_ANOD) begin
        n_miss++;
        $display("FAIL dac_outside_phase: shape=0x%0h, DAC required 0 (cycle %0d)", shape, cyc);
      end
      exp_lvl = ((cyc / DIV_HALF) % 2) == 1;
      if (gn[0] != clk20_prev || gn[0] !== exp_lvl) check("clk_20khz_edge", 32'(gn[0]), 32'(exp_lvl));
      if (tb_if.tick) n_rise++;
      clk20_prev = gn[0];
      if (shape != prev_shape) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_change: shape 0x%0h, none expected (cycle %0d)", shape, cyc);
        end else begin
          e = sb_q.pop_front();
          check("pulse_shape", 32'(shape), 32'(e.shape));
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
        prev_shape = shape;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s;
    gp  = 6'b000000;
    btn = 7'h55;
    repeat (5) @(negedge clk);
    check("reset_gn", 32'(gn), 32'h0);
    check("reset_led", 32'(led), 32'h0);
    gp[0] = 1'b1;

    wait_cyc(200);
    check("disabled_gn", 32'(gn[13:1]), 32'h0);
    check("disabled_led", 32'(led), 32'h0);
    check("tick_count", 32'(n_rise), 32'd10);

    gp[1] = 1'b1;
    s = next_tick(200);
    for (int p = 0; p < 4; p++) push_pulse(s + p * PULSE_CYC);
    wait_cyc(s + 3 * PULSE_CYC + 12 * TICK_CYC);
    check("pulse_count_4", 32'(led[5:0]), 32'd4);
    check("led_enable", 32'(led[6]), 32'd1);
    check("queue_drained_1", 32'(sb_q.size()), 32'd0);

    s = s + 4 * PULSE_CYC;
    push(SH_CATH,  s);
    push(SH_INTER, s + 4 * TICK_CYC);
    push(SH_ANOD,  s + 5 * TICK_CYC);
    push(SH_IDLE,  s + 7 * TICK_CYC + 3);
    wait_cyc(s + 7 * TICK_CYC);
    gp[1] = 1'b0;
    wait_cyc(s + 7 * TICK_CYC + 2);
    check("led_enable_low", 32'(led[6]), 32'd0);
    check("pulse_count_5", 32'(led[5:0]), 32'd5);

    wait_cyc(2000);
    gp[1] = 1'b1;
    s = next_tick(2000);
    push_pulse(s);
    push(SH_CATH, s + PULSE_CYC);
    wait_cyc(s + PULSE_CYC + 2 * TICK_CYC);
    check("pulse_count_7", 32'(led[5:0]), 32'd7);
    check("led_active", 32'(led[7]), 32'd1);
    check("queue_drained_2", 32'(sb_q.size()), 32'd0);

    gp[0] = 1'b0;
    #1;
    check("midpulse_reset_gn", 32'(gn), 32'h0);
    check("midpulse_reset_led", 32'(led), 32'h0);
    repeat (3) @(negedge clk);
    check("queue_final", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
